// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the load/store responder: FSM encodings, word width,
// and the ALU opcodes that the core maps onto load/store requests.
package data_mem_responder_pkg;

    localparam int WORD_WIDTH = 16;

    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // An address is implemented only if every bit above the RAM index is zero.
    function automatic logic addr_in_range(input logic [WORD_WIDTH-1:0] addr, input int aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port word RAM: synchronous write, asynchronous read, no reset.
module data_ram
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Target side of the load/store path: one outstanding request, programmable
// wait states, range-checked access to a word RAM.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [WORD_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy
);

    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_e                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  load_rsp, rsp_done;

    logic                  lat_write, lat_in_range;
    logic [ADDR_WIDTH-1:0] lat_addr;

    logic                  accept, req_in_range;
    logic                  sel_write, sel_in_range;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WORD_WIDTH-1:0] ram_rdata, rdata_nxt;

    assign req_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign accept       = req_valid & req_ready;
    assign req_in_range = addr_in_range(req_addr, ADDR_WIDTH);

    // Stores commit on the accept edge; out-of-range stores never touch the RAM.
    assign ram_we = accept & req_write & req_in_range;

    // In IDLE the live request drives the RAM (needed for the zero-wait path);
    // afterwards the latched copy does.
    assign ram_addr     = req_ready ? req_addr[ADDR_WIDTH-1:0] : lat_addr;
    assign sel_write    = req_ready ? req_write    : lat_write;
    assign sel_in_range = req_ready ? req_in_range : lat_in_range;
    assign rdata_nxt    = (!sel_write && sel_in_range) ? ram_rdata : '0;

    data_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_rsp  = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (NO_WAIT) begin
                        state_nxt = ST_RESP;
                        load_rsp  = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                    load_rsp  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = ST_IDLE;
                    rsp_done  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_write    <= 1'b0;
            lat_in_range <= 1'b0;
            lat_addr     <= '0;
        end else if (accept) begin
            lat_write    <= req_write;
            lat_in_range <= req_in_range;
            lat_addr     <= req_addr[ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (load_rsp) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_nxt;
            rsp_error <= !sel_in_range;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
